// File: rtl/risc_v_mike_instruction_memory_loadable.sv
// -----------------------------------------------------------------------------
// risc_v_mike_instruction_memory_loadable
//
// Instruction memory with a runtime program-load port and a pipelined fetch
// port. A boot loader streams instruction words in over a valid/ready
// handshake. The fetch stage reads them back with a fixed one-cycle latency.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   load_start     pulse: begin, or restart, a program load at word 0
//   load_valid     load beat valid
//   load_data      instruction word carried by the beat
//   load_last      final beat of the program
//   load_ready     registered; high while a beat can be accepted (LOADING)
//   load_overflow  sticky; the program did not end within DATA_MEM_DEPTH words
//   mem_ready      a program is loaded and fetches are served
//   fetch_req      fetch request, sampled every cycle
//   fetch_addr     fetch byte address
//   fetch_valid    one-cycle pulse answering the previous cycle's fetch_req
//   fetch_data     fetched word, or RESET_INSTR when fetch_err is set
//   fetch_err      the fetch was misaligned, out of range or not loaded
//
// Array contents survive reset and reloads. They are only reachable below
// word_count, and word_count is cleared whenever a load starts. Stale words
// therefore can never be fetched.
// -----------------------------------------------------------------------------
module risc_v_mike_instruction_memory_loadable #(
    parameter int                        DATA_MEM_WIDTH = 32,
    parameter int                        DATA_MEM_DEPTH = 1024,
    parameter int                        ADDR_W         = 32,
    parameter logic [DATA_MEM_WIDTH-1:0] RESET_INSTR    = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      load_valid,
    input  logic [DATA_MEM_WIDTH-1:0] load_data,
    input  logic                      load_last,
    output logic                      load_ready,
    output logic                      load_overflow,
    output logic                      mem_ready,
    input  logic                      fetch_req,
    input  logic [ADDR_W-1:0]         fetch_addr,
    output logic                      fetch_valid,
    output logic [DATA_MEM_WIDTH-1:0] fetch_data,
    output logic                      fetch_err
);

    // Word-pointer width, and the word-index width carried by a byte address.
    localparam int AW = $clog2(DATA_MEM_DEPTH);
    localparam int IW = ADDR_W - 2;
    // Common width for the range compare. Indices at or above DEPTH must
    // compare as out of range, never wrap.
    localparam int CW = (IW > AW + 1) ? IW : AW + 1;

    localparam logic [AW-1:0] LAST_PTR = AW'(DATA_MEM_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t                    state_r;
    logic [AW-1:0]             wr_ptr_r;
    logic [AW:0]               word_count_r;
    logic                      load_ready_r;
    logic                      load_overflow_r;
    logic                      mem_ready_r;
    logic                      fetch_valid_r;
    logic                      fetch_err_r;
    logic [DATA_MEM_WIDTH-1:0] fetch_data_r;

    logic [DATA_MEM_WIDTH-1:0] mem_r [DATA_MEM_DEPTH];

    logic                      beat_acc_s;
    logic                      beat_ends_s;
    logic [IW-1:0]             fetch_index_s;
    logic [AW-1:0]             fetch_word_s;
    logic                      fetch_err_s;

    // Range check of a word index against the loaded word count. Both values
    // are widened, so indices beyond the array are caught rather than truncated.
    function automatic logic index_out_of_range(input logic [IW-1:0] index,
                                                input logic [AW:0]   count);
        logic [CW-1:0] index_ext;
        logic [CW-1:0] count_ext;
        index_ext = CW'(index);
        count_ext = CW'(count);
        return (index_ext >= count_ext);
    endfunction

    // Beat acceptance and the end-of-program condition. A beat that arrives
    // together with load_start is dropped: the restart takes priority.
    always_comb begin
        beat_acc_s  = 1'b0;
        beat_ends_s = 1'b0;
        if (load_valid && load_ready_r && !load_start) begin
            beat_acc_s  = 1'b1;
            beat_ends_s = load_last || (wr_ptr_r == LAST_PTR);
        end else begin
            beat_acc_s  = 1'b0;
            beat_ends_s = 1'b0;
        end
    end

    // Fetch fault decode, evaluated against the state at the request edge.
    // Every fetch made during LOADING therefore faults, and so no fetch ever
    // reads a word that is being written in the same cycle.
    always_comb begin
        fetch_index_s = fetch_addr[ADDR_W-1:2];
        fetch_word_s  = fetch_index_s[AW-1:0];
        if (fetch_addr[1:0] != 2'b00) begin
            fetch_err_s = 1'b1;
        end else if (state_r != ST_READY) begin
            fetch_err_s = 1'b1;
        end else begin
            fetch_err_s = index_out_of_range(fetch_index_s, word_count_r);
        end
    end

    // Load FSM: write pointer, word count and the registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_EMPTY;
            wr_ptr_r        <= '0;
            word_count_r    <= '0;
            load_ready_r    <= 1'b0;
            load_overflow_r <= 1'b0;
            mem_ready_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY, ST_READY: begin
                    if (load_start) begin
                        state_r         <= ST_LOADING;
                        wr_ptr_r        <= '0;
                        word_count_r    <= '0;
                        load_ready_r    <= 1'b1;
                        load_overflow_r <= 1'b0;
                        mem_ready_r     <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOADING: begin
                    if (load_start) begin
                        // Restart: discard whatever has been streamed so far.
                        wr_ptr_r        <= '0;
                        word_count_r    <= '0;
                        load_ready_r    <= 1'b1;
                        load_overflow_r <= 1'b0;
                        mem_ready_r     <= 1'b0;
                    end else if (beat_acc_s && beat_ends_s) begin
                        // Final beat: either marked last or the array is full.
                        state_r         <= ST_READY;
                        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
                        word_count_r    <= {1'b0, wr_ptr_r} + CNT_ONE;
                        load_ready_r    <= 1'b0;
                        load_overflow_r <= !load_last;
                        mem_ready_r     <= 1'b1;
                    end else if (beat_acc_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r         <= ST_EMPTY;
                    wr_ptr_r        <= '0;
                    word_count_r    <= '0;
                    load_ready_r    <= 1'b0;
                    load_overflow_r <= 1'b0;
                    mem_ready_r     <= 1'b0;
                end
            endcase
        end
    end

    // Storage array write port. It has no reset: contents are guarded by word_count.
    always_ff @(posedge clk) begin
        if (beat_acc_s) begin
            mem_r[wr_ptr_r] <= load_data;
        end
    end

    // Fetch response register. Its data and error flag hold while no request is made.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
            fetch_data_r  <= RESET_INSTR;
        end else if (fetch_req) begin
            fetch_valid_r <= 1'b1;
            fetch_err_r   <= fetch_err_s;
            fetch_data_r  <= fetch_err_s ? RESET_INSTR : mem_r[fetch_word_s];
        end else begin
            fetch_valid_r <= 1'b0;
        end
    end

    assign load_ready    = load_ready_r;
    assign load_overflow = load_overflow_r;
    assign mem_ready     = mem_ready_r;
    assign fetch_valid   = fetch_valid_r;
    assign fetch_err     = fetch_err_r;
    assign fetch_data    = fetch_data_r;

endmodule

// File: tb/tb_risc_v_mike_instruction_memory_loadable.sv
// Bench for risc_v_mike_instruction_memory_loadable with an 8-word array.
// It checks table vectors, hand-written corner sequences and random traffic
// against a reference model. The model keeps the program as queues of words.
module tb_risc_v_mike_instruction_memory_loadable;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_overflow;
    logic        mem_ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;

    risc_v_mike_instruction_memory_loadable #(
        .DATA_MEM_WIDTH(32),
        .DATA_MEM_DEPTH(DEPTH),
        .ADDR_W        (32),
        .RESET_INSTR   (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_overflow(load_overflow),
        .mem_ready    (mem_ready),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model. A program is the list of words accepted since the
    // last start. The served image is the last program that completed.
    logic        m_loading;
    logic        m_ready;
    logic        m_ovf;
    logic [31:0] m_prog[$];
    logic [31:0] m_image[$];
    logic        m_fv;
    logic        m_ferr;
    logic [31:0] m_fdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_ready   = 1'b0;
        m_ovf     = 1'b0;
        m_prog.delete();
        m_image.delete();
        m_fv      = 1'b0;
        m_ferr    = 1'b0;
        m_fdata   = NOP;
    endtask

    // Applies one clock edge to the model, using the inputs as they were at that edge.
    task automatic model_edge();
        int idx;
        if (fetch_req) begin
            idx    = int'(fetch_addr >> 2);
            m_fv   = 1'b1;
            m_ferr = (fetch_addr[1:0] != 2'b00) || !m_ready || (idx >= m_image.size());
            m_fdata = m_ferr ? NOP : m_image[idx];
        end else begin
            m_fv = 1'b0;
        end
        if (load_start) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_ovf     = 1'b0;
            m_prog.delete();
            m_image.delete();
        end else if (m_loading && load_valid) begin
            m_prog.push_back(load_data);
            if (load_last || m_prog.size() == DEPTH) begin
                m_loading = 1'b0;
                m_ready   = 1'b1;
                m_ovf     = !load_last;
                m_image   = m_prog;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".load_ready"},    {31'd0, load_ready},    {31'd0, m_loading});
        chk({tag, ".load_overflow"}, {31'd0, load_overflow}, {31'd0, m_ovf});
        chk({tag, ".mem_ready"},     {31'd0, mem_ready},     {31'd0, m_ready});
        chk({tag, ".fetch_valid"},   {31'd0, fetch_valid},   {31'd0, m_fv});
        chk({tag, ".fetch_err"},     {31'd0, fetch_err},     {31'd0, m_ferr});
        chk({tag, ".fetch_data"},    fetch_data,             m_fdata);
    endtask

    // Drives one cycle of inputs, clocks the DUT and the model, then compares them 1 ns after the edge.
    task automatic step(input logic ls, input logic lv, input logic [31:0] ld, input logic ll,
                        input logic fr, input logic [31:0] fa, input string tag);
        load_start = ls;
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        fetch_req  = fr;
        fetch_addr = fa;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic        ls;
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic        fr;
        logic [31:0] fa;
        logic        e_fv;
        logic        e_err;
        logic [31:0] e_data;
        logic        e_mr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Each row gives the inputs of one cycle and the outputs expected after that edge.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  1'b1, 1'b1, NOP,          1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h00100093, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00200113, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h002081b3, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h00000013, 1'b1, 1'b1, 32'h0,  1'b1, 1'b1, NOP,          1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h00100093, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,  1'b1, 1'b0, 32'h00200113, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,  1'b1, 1'b0, 32'h002081b3, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,  1'b1, 1'b0, 32'h00000013, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10, 1'b1, 1'b1, NOP,          1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2,  1'b1, 1'b1, NOP,          1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 1'b1, NOP,          1'b1};

        rst = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.fetch_data_const", fetch_data, NOP);
        rst = 1'b1;

        // Directed table: first load, back-to-back fetches, range and alignment faults.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].ls, vecs[i].lv, vecs[i].ld, vecs[i].ll, vecs[i].fr, vecs[i].fa,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_fv", i),   {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
            chk($sformatf("vec%0d.tbl_err", i),  {31'd0, fetch_err},   {31'd0, vecs[i].e_err});
            chk($sformatf("vec%0d.tbl_data", i), fetch_data,           vecs[i].e_data);
            chk($sformatf("vec%0d.tbl_mr", i),   {31'd0, mem_ready},   {31'd0, vecs[i].e_mr});
        end

        // Overflow: 9 beats with no last. Eight are accepted and the ninth is ignored.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "ovf.start");
        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 32'h0, $sformatf("ovf.beat%0d", i));
        chk("ovf.flag", {31'd0, load_overflow}, 32'd1);
        chk("ovf.ready_low", {31'd0, load_ready}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1C, "ovf.fetch7");
        chk("ovf.word7", fetch_data, 32'hA000_0007);
        chk("ovf.word7_err", {31'd0, fetch_err}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, "ovf.fetch8");
        chk("ovf.word8_err", {31'd0, fetch_err}, 32'd1);

        // Restart mid-load: the beat coincident with load_start is dropped.
        step(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, "rs.start");
        step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, "rs.b0");
        step(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, "rs.b1");
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "rs.restart");
        step(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, "rs.c0");
        step(1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0, "rs.c1");
        step(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8, "rs.fetch8");
        chk("rs.fetch8_err", {31'd0, fetch_err}, 32'd1);
        step(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0, "rs.fetch0");
        chk("rs.word0", fetch_data, 32'h3333_3333);
        step(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4, "rs.fetch4");
        chk("rs.word1", fetch_data, 32'h4444_4444);

        // Asynchronous reset in the middle of a load.
        step(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0, "ar.start");
        step(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0, "ar.b0");
        load_valid = 1'b0; fetch_req = 1'b0; load_start = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_model("ar.asserted");
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, "ar.fetch_after");
        chk("ar.fetch_after_err", {31'd0, fetch_err}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] fa;
            fa = {26'd0, 6'($urandom_range(0, 40))};
            if ($urandom_range(0, 3) != 0) fa[1:0] = 2'b00;
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, $urandom,
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, fa,
                 $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_v_mike_instruction_memory_loadable.md
Name: risc_v_mike_instruction_memory_loadable

Overview:
Parametrised successor to the core's instruction memory. It adds a runtime program-load port: a streaming word loader with a valid/ready handshake and a load FSM. It also adds a registered, fully pipelined fetch port with one-cycle latency and an error flag covering misaligned, out-of-range and not-loaded fetches. It sits between the testbench/boot loader and the fetch stage, and returns a NOP on any faulting fetch.

Parameters:
DATA_MEM_WIDTH, 32, instruction word width in bits
DATA_MEM_DEPTH, 1024, number of words; power of two, >= 2
ADDR_W, 32, fetch byte-address width
RESET_INSTR, 32'h00000013, word returned at reset and on any error (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
load_start  input  1  pulse; begins or restarts a program load at word 0
load_valid  input  1  load beat valid
load_data  input  DATA_MEM_WIDTH  instruction word to store
load_last  input  1  marks the final beat of the program
load_ready  output  1  high when a beat can be accepted
load_overflow  output  1  sticky: program exceeded DATA_MEM_DEPTH
mem_ready  output  1  a program is loaded and fetches are served
fetch_req  input  1  fetch request, sampled every cycle
fetch_addr  input  ADDR_W  fetch byte address
fetch_valid  output  1  one-cycle pulse, response to fetch_req from the previous cycle
fetch_data  output  DATA_MEM_WIDTH  fetched instruction
fetch_err  output  1  qualifies fetch_data as RESET_INSTR due to a fault

Behaviour:
- Reset (rst=0, asynchronous):
  - state=EMPTY; wr_ptr=0; word_count=0
  - load_ready=0, load_overflow=0, mem_ready=0
  - fetch_valid=0, fetch_err=0, fetch_data=RESET_INSTR
  - Array contents are not cleared. They are unreadable until a new load completes because word_count=0.
- FSM states: EMPTY, LOADING, READY.
  - EMPTY --load_start--> LOADING
  - LOADING --accepted beat with load_last--> READY
  - LOADING --accepted beat at wr_ptr=DEPTH-1 without load_last--> READY, and load_overflow is set
  - READY --load_start--> LOADING
  - LOADING --load_start--> LOADING (restart)
- Entering or restarting LOADING: wr_ptr=0, word_count=0, load_overflow=0, mem_ready=0.
- load_ready is a registered output, equal to (state==LOADING).
- Beat accepted when load_valid & load_ready & !load_start:
  - writes mem[wr_ptr] and increments wr_ptr
  - on exit to READY, word_count = wr_ptr+1 (range 1..DEPTH) and mem_ready=1
- A beat coincident with load_start is dropped; start has priority.
- load_valid outside LOADING is ignored.
- Fetch is fully pipelined: a request accepted each cycle gets a response on the next cycle.
  - Index = fetch_addr[ADDR_W-1:2].
  - err = (fetch_addr[1:0]!=0) | (index >= word_count) | (state!=READY), all evaluated at the request edge.
  - Next cycle: fetch_valid=1, fetch_err=err, fetch_data = err ? RESET_INSTR : mem[index].
- With fetch_req=0: fetch_valid=0 next cycle; fetch_data and fetch_err hold their last values.
- Load/fetch collision is impossible: every fetch during LOADING errors, so no read-during-write ordering is needed.
- A fetch issued in the same cycle as the final load beat errors; the state is still LOADING at that edge.
- Index >= DEPTH is always out of range, because word_count <= DEPTH. No wrap-around.
- Width rules: wr_ptr is clog2(DEPTH) bits. word_count is clog2(DEPTH)+1 bits so that the value DEPTH is representable.

Test Plan:
- Reset, then fetch_req with addr 0x0 -> next cycle fetch_valid=1, fetch_err=1, fetch_data=0x00000013, mem_ready=0.
- load_start, then 4 beats 0x00100093, 0x00200113, 0x002081b3, 0x00000013 (last on beat 4); fetch 0x0, 0x4, 0x8, 0xC back-to-back -> 4 consecutive valid responses with the same words, err=0, mem_ready=1.
- After that load, fetch 0x10 and 0x2 -> err=1 with RESET_INSTR for both (out of range, misaligned).
- DEPTH=8: stream 9 beats with no last -> 8 accepted, state READY, load_overflow=1, load_ready=0, word_count=8; fetch 0x1C returns word 7, err=0.
- load_start asserted mid-load after 2 beats, coincident with a valid beat -> beat dropped; subsequent 2 beats land at words 0 and 1; fetch 0x8 -> err=1.
- rst asserted while LOADING -> all outputs return to reset values immediately; a fetch after rst release errors until a new load completes.
